// File: rtl/clk_rate_mon_multi.sv
// clk_rate_mon_multi: counts transitions on NCH asynchronous toggle inputs
// over a programmable window of clk_ref cycles, publishes the counts and
// raises sticky per-channel low/high rate alarms against shared thresholds.

// One monitored channel: input synchronizer, edge detect, saturating counter.
module clk_rate_mon_lane #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 3
) (
    input  logic             clk_ref,
    input  logic             reset_in,
    input  logic             tick_in,
    input  logic             clr,     // start of a fresh window
    input  logic             cnt_en,  // window open, edges are counted
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   edge_det;

    // Shift the async input in, detect either edge, count with saturation
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], tick_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (cnt_en && edge_det) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lane state registers
    always_ff @(posedge clk_ref) begin
        if (reset_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

module clk_rate_mon_multi #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 24,
    parameter int WIN_W       = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic                    clk_ref,
    input  logic                    reset_in,
    input  logic [NCH-1:0]          tick_in,
    input  logic                    enable,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [CNT_W-1:0]        thr_lo,
    input  logic [CNT_W-1:0]        thr_hi,
    input  logic                    alarm_clr,
    input  logic [$clog2(NCH)-1:0]  rd_sel,
    output logic [NCH*CNT_W-1:0]    values,
    output logic [CNT_W-1:0]        rd_value,
    output logic                    valid,
    output logic [NCH-1:0]          alarm_lo,
    output logic [NCH-1:0]          alarm_hi,
    output logic [NCH-1:0]          overflow,
    output logic                    busy
);
    // Holdoff lets the synchronizers flush reset state before a first window
    localparam int HOLD_INIT = SYNC_STAGES + 1;
    localparam int HOLD_W    = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_LATCH} state_t;

    state_t                        state_q, state_d;
    logic [WIN_W-1:0]              win_q, win_d;
    logic [HOLD_W-1:0]             hold_q, hold_d;
    logic [NCH-1:0][CNT_W-1:0]     values_q, values_d;
    logic [NCH-1:0]                ovf_q, ovf_d;
    logic [NCH-1:0]                alo_q, alo_d, ahi_q, ahi_d;
    logic                          valid_q, valid_d;
    logic [CNT_W-1:0]              rd_q, rd_d;

    logic                          lane_clr, lane_en, latch;
    logic [NCH-1:0][CNT_W-1:0]     lane_cnt;
    logic [NCH-1:0]                lane_ovf;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        clk_rate_mon_lane #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk_ref  (clk_ref),
            .reset_in (reset_in),
            .tick_in  (tick_in[g]),
            .clr      (lane_clr),
            .cnt_en   (lane_en),
            .cnt      (lane_cnt[g]),
            .ovf      (lane_ovf[g])
        );
    end

    // State register plus all published results
    always_ff @(posedge clk_ref) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            hold_q   <= HOLD_W'(HOLD_INIT);
            values_q <= '1;
            ovf_q    <= '0;
            alo_q    <= '0;
            ahi_q    <= '0;
            valid_q  <= 1'b0;
            rd_q     <= '1;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            values_q <= values_d;
            ovf_q    <= ovf_d;
            alo_q    <= alo_d;
            ahi_q    <= ahi_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
        end
    end

    // Next state; dropping enable mid-window abandons it without a latch
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable && hold_q == '0) state_d = S_ARM;
            S_ARM:     state_d = S_MEASURE;
            S_MEASURE: begin
                if (!enable)                 state_d = S_IDLE;
                else if (win_q == WIN_W'(1)) state_d = S_LATCH;
            end
            S_LATCH:   state_d = enable ? S_ARM : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        lane_clr = (state_q == S_ARM);
        lane_en  = (state_q == S_MEASURE);
        latch    = (state_q == S_LATCH);
        busy     = (state_q != S_IDLE);
    end

    // Window/holdoff counters, result capture, sticky alarms and readout mux
    always_comb begin
        hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
        win_d  = win_q;
        if (state_q == S_ARM)
            win_d = (win_len == '0) ? WIN_W'(1) : win_len;
        else if (state_q == S_MEASURE && win_q != '0)
            win_d = win_q - WIN_W'(1);

        values_d = values_q;
        ovf_d    = ovf_q;
        valid_d  = latch;
        // clear first so a flag raised by the same LATCH survives alarm_clr
        alo_d    = alarm_clr ? '0 : alo_q;
        ahi_d    = alarm_clr ? '0 : ahi_q;
        for (int i = 0; i < NCH; i++) begin
            if (latch) begin
                values_d[i] = lane_cnt[i];
                ovf_d[i]    = lane_ovf[i];
                if (lane_cnt[i] < thr_lo) alo_d[i] = 1'b1;
                if (lane_cnt[i] > thr_hi) ahi_d[i] = 1'b1;
            end
        end

        rd_d = '0;
        for (int i = 0; i < NCH; i++)
            if (int'(rd_sel) == i) rd_d = values_q[i];
    end

    assign values   = values_q;
    assign rd_value = rd_q;
    assign valid    = valid_q;
    assign alarm_lo = alo_q;
    assign alarm_hi = ahi_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_clk_rate_mon_multi.sv
// Directed bench for clk_rate_mon_multi: a 24-bit instance for the main
// behaviour and an 8-bit instance sharing the same inputs for saturation.
`timescale 1ns/1ps
module tb_clk_rate_mon_multi;
    localparam int NCH = 4, CNT_W = 24, WIN_W = 32, SS = 3;

    logic                   clk_ref = 1'b0;
    logic                   reset_in, enable, alarm_clr;
    logic [NCH-1:0]         tick_in = '0;
    logic [WIN_W-1:0]       win_len;
    logic [CNT_W-1:0]       thr_lo, thr_hi;
    logic [1:0]             rd_sel;
    logic [NCH*CNT_W-1:0]   values;
    logic [CNT_W-1:0]       rd_value;
    logic                   valid, busy;
    logic [NCH-1:0]         alarm_lo, alarm_hi, overflow;
    logic [NCH*8-1:0]       values8;
    logic [7:0]             rd_value8;
    logic                   valid8, busy8;
    logic [NCH-1:0]         alo8, ahi8, ovf8;

    int n_cmp = 0;
    int n_bad = 0;
    int per  [NCH] = '{default: 0};
    int tcnt [NCH] = '{default: 0};

    always #5 clk_ref = ~clk_ref;

    clk_rate_mon_multi #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SS)) u_dut (
        .clk_ref(clk_ref), .reset_in(reset_in), .tick_in(tick_in), .enable(enable),
        .win_len(win_len), .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm_clr(alarm_clr),
        .rd_sel(rd_sel), .values(values), .rd_value(rd_value), .valid(valid),
        .alarm_lo(alarm_lo), .alarm_hi(alarm_hi), .overflow(overflow), .busy(busy)
    );

    clk_rate_mon_multi #(.NCH(NCH), .CNT_W(8), .WIN_W(WIN_W), .SYNC_STAGES(SS)) u_dut8 (
        .clk_ref(clk_ref), .reset_in(reset_in), .tick_in(tick_in), .enable(enable),
        .win_len(win_len), .thr_lo(thr_lo[7:0]), .thr_hi(thr_hi[7:0]), .alarm_clr(alarm_clr),
        .rd_sel(rd_sel), .values(values8), .rd_value(rd_value8), .valid(valid8),
        .alarm_lo(alo8), .alarm_hi(ahi8), .overflow(ovf8), .busy(busy8)
    );

    // Toggle generator: channel i flips every per[i] cycles, 0 means static
    always @(negedge clk_ref) begin
        for (int i = 0; i < NCH; i++) begin
            if (per[i] == 0) tcnt[i] = 0;
            else if (tcnt[i] >= per[i] - 1) begin
                tcnt[i] = 0;
                tick_in[i] = ~tick_in[i];
            end else tcnt[i]++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CNT_W-1:0] ch(input int i);
        return values[i*CNT_W +: CNT_W];
    endfunction

    task automatic wait_valid(input int limit, output bit ok, output int cyc);
        ok = 0; cyc = 0;
        while (cyc < limit && !ok) begin
            @(negedge clk_ref); cyc++;
            if (valid) ok = 1;
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk_ref);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL go_idle: busy %b want 0", busy); end
    endtask

    task automatic test_reset();
        bit sawv = 0, sawb = 0;
        reset_in = 1'b1;
        repeat (3) @(negedge clk_ref);
        reset_in = 1'b0;
        @(negedge clk_ref);
        n_cmp++; if (values !== '1) begin n_bad++; $display("FAIL reset_values: got %h want all-ones", values); end
        n_cmp++; if (values8 !== '1) begin n_bad++; $display("FAIL reset_values8: got %h want all-ones", values8); end
        n_cmp++; if (rd_value !== 24'hFFFFFF) begin n_bad++; $display("FAIL reset_rd_value: got %h want ffffff", rd_value); end
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_valid_busy: got %b want 00", {valid, busy}); end
        n_cmp++; if ({alarm_lo, alarm_hi, overflow} !== 12'h000) begin n_bad++; $display("FAIL reset_flags: got %h want 000", {alarm_lo, alarm_hi, overflow}); end
        repeat (50) begin
            @(negedge clk_ref);
            if (valid) sawv = 1;
            if (busy)  sawb = 1;
        end
        n_cmp++; if (sawv) begin n_bad++; $display("FAIL idle_valid: got 1 want 0"); end
        n_cmp++; if (sawb) begin n_bad++; $display("FAIL idle_busy: got 1 want 0"); end
        n_cmp++; if (values !== '1) begin n_bad++; $display("FAIL idle_values: got %h want all-ones", values); end
        n_cmp++; if (rd_value !== 24'hFFFFFF) begin n_bad++; $display("FAIL idle_rd_value: got %h want ffffff", rd_value); end
    endtask

    task automatic test_window();
        bit ok; int c;
        thr_lo = '0; thr_hi = '1; win_len = 100;
        per[0] = 4; per[1] = 0; per[2] = 0; per[3] = 0;
        enable = 1'b1;
        wait_valid(400, ok, c);
        n_cmp++; if (!ok || c != 103) begin n_bad++; $display("FAIL first_latency: ok %b cycles %0d want 103", ok, c); end
        wait_valid(200, ok, c);
        n_cmp++; if (!ok || c != 102) begin n_bad++; $display("FAIL period: ok %b cycles %0d want 102", ok, c); end
        n_cmp++; if (ch(0) < 24 || ch(0) > 26) begin n_bad++; $display("FAIL win_ch0: got %0d want 25+/-1", ch(0)); end
        for (int i = 1; i < NCH; i++) begin
            n_cmp++; if (ch(i) !== '0) begin n_bad++; $display("FAIL win_ch%0d: got %0d want 0", i, ch(i)); end
        end
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL win_overflow: got %b want 0000", overflow); end
        rd_sel = 2'd1;
        repeat (2) @(negedge clk_ref);
        n_cmp++; if (rd_value !== '0) begin n_bad++; $display("FAIL rd_sel1: got %0d want 0", rd_value); end
        rd_sel = 2'd0;
        repeat (2) @(negedge clk_ref);
        n_cmp++; if (rd_value < 24 || rd_value > 26) begin n_bad++; $display("FAIL rd_sel0: got %0d want 25+/-1", rd_value); end
        go_idle();
    endtask

    task automatic test_overflow();
        bit ok; int c;
        win_len = 1000; per[0] = 2;
        enable = 1'b1;
        wait_valid(1200, ok, c);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_valid: no valid within 1200 cycles"); end
        n_cmp++; if (values8[7:0] !== 8'hFF) begin n_bad++; $display("FAIL sat_ch0: got %0d want 255", values8[7:0]); end
        n_cmp++; if (ovf8 !== 4'b0001) begin n_bad++; $display("FAIL sat_overflow: got %b want 0001", ovf8); end
        n_cmp++; if (ch(0) < 499 || ch(0) > 501) begin n_bad++; $display("FAIL wide_ch0: got %0d want 500+/-1", ch(0)); end
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL wide_overflow: got %b want 0000", overflow); end
        per[0] = 8;
        wait_valid(1100, ok, c);
        wait_valid(1100, ok, c);
        n_cmp++; if (!ok || c != 1002) begin n_bad++; $display("FAIL ovf_period: ok %b cycles %0d want 1002", ok, c); end
        n_cmp++; if (values8[7:0] < 124 || values8[7:0] > 126) begin n_bad++; $display("FAIL slow_ch0: got %0d want 125+/-1", values8[7:0]); end
        n_cmp++; if (ovf8 !== 4'b0000) begin n_bad++; $display("FAIL slow_overflow: got %b want 0000", ovf8); end
        go_idle();
    endtask

    task automatic test_alarm();
        bit ok; int c;
        thr_lo = 20; thr_hi = 30; win_len = 100;
        alarm_clr = 1'b1; @(negedge clk_ref); alarm_clr = 1'b0;
        per[0] = 4; per[1] = 0; per[2] = 2; per[3] = 0;
        enable = 1'b1;
        wait_valid(300, ok, c);
        n_cmp++; if (!ok || alarm_lo !== 4'b1010) begin n_bad++; $display("FAIL alarm_lo_set: got %b want 1010", alarm_lo); end
        n_cmp++; if (alarm_hi !== 4'b0100) begin n_bad++; $display("FAIL alarm_hi_set: got %b want 0100", alarm_hi); end
        per[1] = 4; per[2] = 4; per[3] = 4;
        wait_valid(200, ok, c);
        wait_valid(200, ok, c);
        n_cmp++; if (!ok || alarm_lo !== 4'b1010) begin n_bad++; $display("FAIL alarm_lo_sticky: got %b want 1010", alarm_lo); end
        n_cmp++; if (alarm_hi !== 4'b0100) begin n_bad++; $display("FAIL alarm_hi_sticky: got %b want 0100", alarm_hi); end
        // ch1 goes static again; clear is driven into the LATCH of this window
        per[1] = 0;
        repeat (101) @(negedge clk_ref);
        alarm_clr = 1'b1;
        @(negedge clk_ref);
        alarm_clr = 1'b0;
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL clr_on_latch_valid: got %b want 1", valid); end
        n_cmp++; if (alarm_lo !== 4'b0010) begin n_bad++; $display("FAIL clr_alarm_lo: got %b want 0010", alarm_lo); end
        n_cmp++; if (alarm_hi !== 4'b0000) begin n_bad++; $display("FAIL clr_alarm_hi: got %b want 0000", alarm_hi); end
        go_idle();
    endtask

    task automatic test_abort();
        bit ok, sawv = 0; int c, nv = 0;
        thr_lo = '0; thr_hi = '1; win_len = 100;
        per[0] = 4; per[1] = 0; per[2] = 0; per[3] = 0;
        enable = 1'b1;
        wait_valid(300, ok, c);
        wait_valid(200, ok, c);
        n_cmp++; if (!ok || ch(0) < 24 || ch(0) > 26) begin n_bad++; $display("FAIL abort_pre_ch0: got %0d want 25+/-1", ch(0)); end
        per[0] = 2;
        repeat (40) @(negedge clk_ref);
        enable = 1'b0;
        @(negedge clk_ref);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy %b want 0", busy); end
        per[0] = 4;
        repeat (200) begin
            @(negedge clk_ref);
            if (valid) sawv = 1;
        end
        n_cmp++; if (sawv) begin n_bad++; $display("FAIL abort_valid: got 1 want 0"); end
        n_cmp++; if (ch(0) < 24 || ch(0) > 26) begin n_bad++; $display("FAIL abort_values: got %0d want 25+/-1", ch(0)); end
        n_cmp++; if (alarm_lo !== 4'b0010 || overflow !== 4'b0000) begin n_bad++; $display("FAIL abort_flags: lo %b ovf %b want 0010 0000", alarm_lo, overflow); end
        enable = 1'b1;
        @(negedge clk_ref);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rearm_busy: got %b want 1", busy); end
        repeat (110) begin
            @(negedge clk_ref);
            if (valid) nv++;
        end
        n_cmp++; if (nv != 1) begin n_bad++; $display("FAIL rearm_valid_count: got %0d want 1", nv); end
        n_cmp++; if (ch(0) < 24 || ch(0) > 26) begin n_bad++; $display("FAIL rearm_ch0: got %0d want 25+/-1", ch(0)); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        bit ok, early = 0; int c;
        per[0] = 4; win_len = 100;
        enable = 1'b1;
        wait_valid(300, ok, c);
        repeat (30) @(negedge clk_ref);
        reset_in = 1'b1;
        @(negedge clk_ref);
        reset_in = 1'b0;
        n_cmp++; if (values !== '1 || rd_value !== 24'hFFFFFF) begin n_bad++; $display("FAIL midrst_values: got %h rd %h want all-ones", values, rd_value); end
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_valid_busy: got %b want 00", {valid, busy}); end
        n_cmp++; if ({alarm_lo, alarm_hi, overflow} !== 12'h000) begin n_bad++; $display("FAIL midrst_flags: got %h want 000", {alarm_lo, alarm_hi, overflow}); end
        repeat (SS + 1) begin
            @(negedge clk_ref);
            if (busy || valid) early = 1;
        end
        n_cmp++; if (early) begin n_bad++; $display("FAIL holdoff: busy/valid seen within %0d cycles of release", SS + 1); end
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk_ref);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL post_reset_arm: busy %b want 1", busy); end
        wait_valid(300, ok, c);
        n_cmp++; if (!ok || ch(0) < 24 || ch(0) > 26) begin n_bad++; $display("FAIL post_reset_ch0: ok %b got %0d want 25+/-1", ok, ch(0)); end
        go_idle();
    endtask

    initial begin
        reset_in = 1'b1; enable = 1'b0; alarm_clr = 1'b0;
        win_len = 100; thr_lo = '0; thr_hi = '1; rd_sel = 2'd0;
        test_reset();
        test_window();
        test_overflow();
        test_alarm();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clk_rate_mon_multi.md
CLK_RATE_MON_MULTI -- requirements
Module: clk_rate_mon_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored channels.
REQ-002 SHALL have parameter CNT_W, default 24, width of each per-channel count.
REQ-003 SHALL have parameter WIN_W, default 32, width of the window-length input.
REQ-004 SHALL have parameter SYNC_STAGES, default 3, flip-flops per input synchronizer (minimum 2).
REQ-005 SHALL have port clk_ref  in  1  sole clock; all logic is in this domain.
REQ-006 SHALL have port reset_in  in  1  reset, synchronous to clk_ref, active-high.
REQ-007 SHALL have port tick_in  in  NCH  asynchronous toggle inputs; each transition is one event (test clock divided down externally).
REQ-008 SHALL have port enable  in  1  run continuous measurement windows while high.
REQ-009 SHALL have port win_len  in  WIN_W  window length in clk_ref cycles, sampled in ARM.
REQ-010 SHALL have port thr_lo  in  CNT_W  low alarm threshold, shared by all channels.
REQ-011 SHALL have port thr_hi  in  CNT_W  high alarm threshold, shared by all channels.
REQ-012 SHALL have port alarm_clr  in  1  clear all sticky alarms.
REQ-013 SHALL have port rd_sel  in  $clog2(NCH)  readout channel select.
REQ-014 SHALL have port values  out  NCH*CNT_W  last completed counts; channel i in bits [i*CNT_W +: CNT_W].
REQ-015 SHALL have port rd_value  out  CNT_W  registered values[rd_sel].
REQ-016 SHALL have port valid  out  1  one-cycle pulse when values update.
REQ-017 SHALL have ports alarm_lo, alarm_hi, overflow  out  NCH each  per-channel status flags.
REQ-018 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-019 SHALL synchronize each tick_in bit through SYNC_STAGES flops, then detect any edge by comparing against a one-cycle-delayed copy.
REQ-020 SHALL require each tick_in level to be stable for at least 2 clk_ref cycles; faster inputs are out of scope (undercount allowed).
REQ-021 SHALL implement FSM IDLE, ARM, MEASURE, LATCH.
REQ-022 IDLE: counters held; SHALL go to ARM when enable=1, but not before SYNC_STAGES+1 cycles after reset deasserts.
REQ-023 ARM (1 cycle): SHALL clear all counters, load window counter with win_len (0 treated as 1), go to MEASURE.
REQ-024 MEASURE: SHALL increment counter i on each detected edge of channel i; window counter decrements; after exactly win_len cycles go to LATCH.
REQ-025 Edges in ARM, LATCH or IDLE SHALL be discarded; window period is win_len+2 cycles.
REQ-026 A counter at all-ones SHALL saturate; a further edge SHALL set a window-local overflow bit for that channel.
REQ-027 LATCH (1 cycle): SHALL copy counts to values, copy window overflow bits to overflow, pulse valid, then go to ARM if enable=1 else IDLE.
REQ-028 In LATCH, SHALL set alarm_lo[i] if count_i < thr_lo and alarm_hi[i] if count_i > thr_hi (unsigned); equality raises neither.
REQ-029 alarm_lo/alarm_hi SHALL be sticky until alarm_clr; alarm_clr coincident with LATCH: new set wins for flagged bits, others clear.
REQ-030 enable=0 during MEASURE SHALL abort to IDLE next cycle: no valid, values/overflow/alarms unchanged.
REQ-031 win_len changes SHALL take effect only at the next ARM.
REQ-032 rd_value SHALL update one cycle after rd_sel/values change; rd_sel >= NCH SHALL give 0.

Reset
REQ-033 On reset_in=1: state IDLE, values and rd_value all-ones (no measurement yet), valid/alarm_lo/alarm_hi/overflow/busy 0, synchronizers and counters 0.
REQ-034 Reset asserted mid-MEASURE SHALL discard the window with no valid pulse.

Verification
REQ-035 Reset then enable=0 for 50 cycles -> values all-ones, rd_value 24'hFFFFFF, valid never asserts, busy 0.
REQ-036 win_len=100, tick_in[0] toggles every 4 cycles, others static -> valid every 102 cycles, values ch0 = 25 +/-1, ch1-3 = 0.
REQ-037 CNT_W=8, win_len=1000, tick_in[0] toggles every 2 cycles -> ch0 = 255, overflow[0]=1; next window at 8-cycle toggle -> 125 +/-1, overflow[0]=0.
REQ-038 thr_lo=20, thr_hi=30, win_len=100, ch1 static, ch2 toggles every 2 cycles -> alarm_lo[1]=1, alarm_hi[2]=1, persist after ch1/ch2 recover; alarm_clr on a LATCH cycle re-flagging only ch1 -> alarm_lo[1]=1, alarm_hi[2]=0.
REQ-039 enable dropped 40 cycles into a window -> IDLE next cycle, no valid, values unchanged; re-enable -> ARM, full window, one valid.
REQ-040 reset_in pulsed mid-MEASURE -> no valid, all outputs to REQ-033 values; ARM not entered within SYNC_STAGES+1 cycles of release.
